isa_test_monitor: RTL

Synthesisable multi-channel completion monitor for RV32I ISA regression runs. Each channel watches one hart's test-status CSR write port. A channel completes when a write has bit 0 set. The payload above bit 0 is the failing test number; zero means pass. The monitor sits beside `SMU_RV32I_System` instances in simulation and FPGA self-test builds, and replaces per-bench wait/timeout logic with a registered pass/fail/timeout verdict, per-channel cycle counts and a read-back mux.

---
 rtl/isa_mon_pkg.sv | 16 +
 rtl/isa_mon_channel.sv | 44 ++++
 rtl/isa_test_monitor.sv | 118 +++++++++++
 3 files changed

// File: rtl/isa_mon_pkg.sv
// Shared definitions for the ISA regression completion monitor:
// verdict state encodings and status-CSR field positions.
package isa_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } mon_state_t;

  localparam int DONE_BIT = 0;
  localparam int CODE_LO  = 1;

endpackage

// File: rtl/isa_mon_channel.sv
// One monitored hart: latches the first completing status write
// (done, fail, test code, cycle of completion) while the run is armed.
module isa_mon_channel
  import isa_mon_pkg::*;
#(
  parameter int CSR_W = 32,
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             we,
  input  logic [CSR_W-1:0] wdata,
  input  logic [CYC_W-1:0] cycles,
  output logic             done_nxt,
  output logic             fail_nxt,
  output logic             done,
  output logic             fail,
  output logic [CSR_W-2:0] code,
  output logic [CYC_W-1:0] cyc
);

  logic capture;

  // Progress writes (done bit clear) and any write after the first completion are dropped.
  assign capture  = arm && we && wdata[DONE_BIT] && !done;
  assign done_nxt = done | capture;
  assign fail_nxt = capture ? (|wdata[CSR_W-1:CODE_LO]) : fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      done <= 1'b0;
      fail <= 1'b0;
      code <= '0;
      cyc  <= '0;
    end else if (capture) begin
      done <= 1'b1;
      fail <= |wdata[CSR_W-1:CODE_LO];
      code <= wdata[CSR_W-1:CODE_LO];
      cyc  <= cycles;
    end
  end

endmodule

// File: rtl/isa_test_monitor.sv
// Multi-channel RV32I regression completion monitor: run FSM with
// registered pass/fail/timeout verdict, global cycle counter and read-back mux.
module isa_test_monitor
  import isa_mon_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CSR_W          = 32,
  parameter int CYC_W          = 32,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int STOP_ON_FAIL   = 1,
  localparam int SEL_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       csr_we,
  input  logic [NUM_CH*CSR_W-1:0] csr_wdata,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [2:0]              state,
  output logic                    done,
  output logic                    all_pass,
  output logic [NUM_CH-1:0]       ch_done,
  output logic [NUM_CH-1:0]       ch_fail,
  output logic [SEL_W-1:0]        fail_ch,
  output logic [CSR_W-2:0]        rd_code,
  output logic [CYC_W-1:0]        rd_cycles,
  output logic [CYC_W-1:0]        run_cycles
);

  mon_state_t        st;
  logic              arm;
  logic [NUM_CH-1:0] done_nxt;
  logic [NUM_CH-1:0] fail_nxt;
  logic [CSR_W-2:0]  code_arr [NUM_CH];
  logic [CYC_W-1:0]  cyc_arr  [NUM_CH];

  assign state = st;
  assign arm   = (st == ST_RUN);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    isa_mon_channel #(
      .CSR_W(CSR_W),
      .CYC_W(CYC_W)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .arm     (arm),
      .we      (csr_we[i]),
      .wdata   (csr_wdata[i*CSR_W +: CSR_W]),
      .cycles  (run_cycles),
      .done_nxt(done_nxt[i]),
      .fail_nxt(fail_nxt[i]),
      .done    (ch_done[i]),
      .fail    (ch_fail[i]),
      .code    (code_arr[i]),
      .cyc     (cyc_arr[i])
    );
  end

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] v);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Verdicts use next-state channel flags so a capture and its verdict land on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= ST_IDLE;
      done       <= 1'b0;
      all_pass   <= 1'b0;
      run_cycles <= '0;
      fail_ch    <= '0;
    end else begin
      fail_ch <= lowest_set(fail_nxt);
      case (st)
        ST_IDLE: begin
          if (start) begin
            st         <= ST_RUN;
            run_cycles <= '0;
          end
        end
        ST_RUN: begin
          if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
          if ((STOP_ON_FAIL != 0) && (|fail_nxt)) begin
            st   <= ST_FAIL;
            done <= 1'b1;
          end else if (&done_nxt) begin
            done <= 1'b1;
            if (|fail_nxt) begin
              st <= ST_FAIL;
            end else begin
              st       <= ST_PASS;
              all_pass <= 1'b1;
            end
          end else if (run_cycles == CYC_W'(TIMEOUT_CYCLES - 1)) begin
            st   <= ST_TIMEOUT;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_code   = '0;
    rd_cycles = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_code   = code_arr[i];
        rd_cycles = cyc_arr[i];
      end
    end
  end

endmodule
